alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 107 ++++++++++
 tb/tb_alu_result_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry FIFO of {y, N, Z, C, V} with flag generation,
// sticky overflow/illegal-op flags and an accepted-result counter.
module alu_result_stage #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_y,
  input  logic             in_cb,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_y,
  output logic [3:0]       out_flags,
  output logic             sticky_v,
  output logic             sticky_err,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] result_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t       state, state_nx;
  logic [7:0] slot0, slot1;   // slot0 is always the oldest entry
  logic [7:0] entry_new;
  logic       push, pop;
  logic       arith, illegal;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign arith   = (in_op == 3'b000) || (in_op == 3'b001);
  assign illegal = (in_op > 3'b100);
  assign flag_n  = in_y[3];
  assign flag_z  = (in_y == 4'h0);
  assign flag_c  = arith & in_cb;
  assign flag_v  = arith & in_ovf;
  assign entry_new = {in_y, flag_n, flag_z, flag_c, flag_v};

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // Output logic: ready/valid come from registered occupancy only
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    out_y     = '0;
    out_flags = '0;
    if (state != EMPTY) begin
      out_y     = slot0[7:4];
      out_flags = slot0[3:0];
    end
  end

  // A pop shifts slot1 forward; a simultaneous push in ONE lands directly in slot0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      if (pop) slot0 <= slot1;
      if (push) begin
        if (state == EMPTY || (state == ONE && pop)) slot0 <= entry_new;
        else                                         slot1 <= entry_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_v   <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      if (push && flag_v) sticky_v <= 1'b1;
      else if (clr_sticky) sticky_v <= 1'b0;
      if (push && illegal) sticky_err <= 1'b1;
      else if (clr_sticky) sticky_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    result_cnt <= '0;
    else if (push) result_cnt <= result_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (counter narrowed to 2 bits).
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [3:0] in_y;
  logic       in_cb;
  logic       in_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic [3:0] out_flags;
  logic       sticky_v;
  logic       sticky_err;
  logic       clr_sticky;
  logic [1:0] result_cnt;

  int checks = 0;
  int failures = 0;

  alu_result_stage #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_y(in_y),
    .in_cb(in_cb), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags),
    .sticky_v(sticky_v), .sticky_err(sticky_err), .clr_sticky(clr_sticky),
    .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] y,
                       input logic cb, input logic ovf);
    in_valid = v; in_op = op; in_y = y; in_cb = cb; in_ovf = ovf;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    out_ready = 1'b0; clr_sticky = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    out_ready = 1'b0; clr_sticky = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({out_y, out_flags} !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", {out_y, out_flags}); end
    checks++; if ({sticky_v, sticky_err} !== 2'b00) begin failures++; $display("FAIL reset_sticky got=%b exp=00", {sticky_v, sticky_err}); end
    checks++; if (result_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", result_cnt); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 4'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_y !== 4'h0) begin failures++; $display("FAIL add_out_y got=%h exp=0", out_y); end
    checks++; if (out_flags !== 4'b0110) begin failures++; $display("FAIL add_flags got=%b exp=0110", out_flags); end
    checks++; if (result_cnt !== 2'd1) begin failures++; $display("FAIL add_cnt got=%0d exp=1", result_cnt); end
    step();
    checks++; if ({out_valid, out_y, out_flags} !== 9'h000) begin failures++; $display("FAIL add_drained got=%h exp=000", {out_valid, out_y, out_flags}); end
  endtask

  task automatic test_logic_mask();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 4'h9, 1'b1, 1'b1);
    step();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    checks++; if (out_y !== 4'h9) begin failures++; $display("FAIL mask_out_y got=%h exp=9", out_y); end
    checks++; if (out_flags !== 4'b1000) begin failures++; $display("FAIL mask_flags got=%b exp=1000", out_flags); end
    checks++; if (sticky_v !== 1'b0) begin failures++; $display("FAIL mask_sticky_v got=%b exp=0", sticky_v); end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 4'h1, 1'b0, 1'b0);
    step();
    checks++; if ({out_valid, in_ready} !== 2'b11) begin failures++; $display("FAIL bp_one got=%b exp=11", {out_valid, in_ready}); end
    drive(1'b1, 3'b000, 4'h2, 1'b0, 1'b0);
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    drive(1'b1, 3'b000, 4'h3, 1'b0, 1'b0);
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_held_ready got=%b exp=0", in_ready); end
    checks++; if (out_y !== 4'h1) begin failures++; $display("FAIL bp_stable_y got=%h exp=1", out_y); end
    checks++; if (result_cnt !== 2'd2) begin failures++; $display("FAIL bp_held_cnt got=%0d exp=2", result_cnt); end
    out_ready = 1'b1;
    step();
    checks++; if (out_y !== 4'h2) begin failures++; $display("FAIL bp_drain2 got=%h exp=2", out_y); end
    checks++; if (result_cnt !== 2'd2) begin failures++; $display("FAIL bp_pop_full_cnt got=%0d exp=2", result_cnt); end
    step();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    checks++; if (out_y !== 4'h3) begin failures++; $display("FAIL bp_drain3 got=%h exp=3", out_y); end
    checks++; if (result_cnt !== 2'd3) begin failures++; $display("FAIL bp_cnt got=%0d exp=3", result_cnt); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_sticky();
    do_reset();
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    drive(1'b1, 3'b001, 4'h8, 1'b0, 1'b1);
    step();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    checks++; if (sticky_v !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", sticky_v); end
    checks++; if (out_flags !== 4'b1001) begin failures++; $display("FAIL sticky_sub_flags got=%b exp=1001", out_flags); end
    step();
    checks++; if (sticky_v !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", sticky_v); end
    clr_sticky = 1'b0;
    drive(1'b1, 3'b110, 4'h0, 1'b1, 1'b1);
    step();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    checks++; if ({sticky_err, sticky_v} !== 2'b10) begin failures++; $display("FAIL sticky_err got=%b exp=10", {sticky_err, sticky_v}); end
    checks++; if ({out_y, out_flags} !== 8'h04) begin failures++; $display("FAIL sticky_err_data got=%h exp=04", {out_y, out_flags}); end
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    checks++; if (sticky_err !== 1'b0) begin failures++; $display("FAIL sticky_err_clear got=%b exp=0", sticky_err); end
    checks++; if (result_cnt !== 2'd2) begin failures++; $display("FAIL sticky_cnt got=%0d exp=2", result_cnt); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b010, 4'(i + 4), 1'b0, 1'b0);
      step();
      checks++; if (result_cnt !== exp_seq[i]) begin failures++; $display("FAIL wrap_cnt[%0d] got=%0d exp=%0d", i, result_cnt, exp_seq[i]); end
      checks++; if (out_y !== 4'(i + 4)) begin failures++; $display("FAIL wrap_y[%0d] got=%h exp=%h", i, out_y, 4'(i + 4)); end
    end
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 4'hA, 1'b1, 1'b1);
    step();
    drive(1'b1, 3'b111, 4'hB, 1'b0, 1'b0);
    step();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    checks++; if ({in_ready, sticky_v, sticky_err} !== 3'b011) begin failures++; $display("FAIL ar_pre_full got=%b exp=011", {in_ready, sticky_v, sticky_err}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, out_y, out_flags} !== 10'b10_0000_0000) begin failures++; $display("FAIL ar_async_io got=%b exp=1000000000", {in_ready, out_valid, out_y, out_flags}); end
    checks++; if ({sticky_v, sticky_err, result_cnt} !== 4'b0000) begin failures++; $display("FAIL ar_async_state got=%b exp=0000", {sticky_v, sticky_err, result_cnt}); end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 4'h5, 1'b0, 1'b0);
    step();
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0);
    checks++; if ({out_valid, out_y} !== 5'h15) begin failures++; $display("FAIL ar_after_y got=%h exp=15", {out_valid, out_y}); end
    checks++; if (result_cnt !== 2'd1) begin failures++; $display("FAIL ar_after_cnt got=%0d exp=1", result_cnt); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_logic_mask();
    test_backpressure();
    test_sticky();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
